hash_arbiter: RTL and testbench
===============================

Name: hash_arbiter

Overview:
Shares one sha256XMSS instance among NUM_REQ hash requesters, such as seed expansion, gen_chain and L-tree/leaf hashing. Each requester keeps its native start/done hash interface.
- Arbitration is round-robin; a grant is held until the core reports done.
- A requester that stored the intermediate state keeps exclusive ownership until it consumes that state.
- Sits between the requesters and sha256XMSS, replacing the ad-hoc start/data muxing in the WOTS/XMSS top levels.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
REQ_W, `CLOG2(NUM_REQ), width of grant index (derived, do not override)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_start  in  NUM_REQ  per-requester one-cycle start pulse
req_data_in  in  1024*NUM_REQ  flattened; slice i = bits [1024*i +: 1024]
req_message_length  in  NUM_REQ  per-requester message_length
req_store_intermediate  in  NUM_REQ  per-requester store_intermediate
req_continue_intermediate  in  NUM_REQ  per-requester continue_intermediate
req_done  out  NUM_REQ  one-hot done pulse to the owning requester
req_busy  out  NUM_REQ  requester i has a pending or in-flight job
hash_start  out  1  start pulse to sha256XMSS
hash_data_in  out  1024  muxed data to sha256XMSS
hash_message_length  out  1  muxed
hash_store_intermediate  out  1  muxed
hash_continue_intermediate  out  1  muxed
hash_done  in  1  done from sha256XMSS; hash_data_out is routed directly to all requesters, not through this block
grant  out  REQ_W  current owner index
locked  out  1  intermediate-state lock held

Behaviour:
Reset values:
- All outputs 0, pending 0, last_grant = NUM_REQ-1 (so requester 0 wins first), FSM in IDLE.
- Reset mid-operation aborts the job silently; no req_done is issued.

Requester protocol:
- Requester i holds its data/length/flags stable from the req_start pulse until its req_done.
- On req_start[i]: pending[i] <= 1.
- A req_start[i] while pending[i] or in flight is ignored.

FSM states IDLE, ISSUE, WAIT:
- IDLE with unlocked: select the first pending index scanning last_grant+1, last_grant+2, ... modulo NUM_REQ. Register it into grant and go to ISSUE.
- IDLE with locked: consider only pending[grant]; others wait.
- IDLE with none eligible: stay in IDLE.
- ISSUE: hash_start=1 for exactly one cycle; clear pending[grant]; go to WAIT.
- WAIT: hold until hash_done. In the hash_done cycle, req_done[grant]=1 (combinational AND of hash_done and the WAIT state), last_grant <= grant, then go to IDLE.

Mux outputs:
- hash_data_in, hash_message_length and the intermediate flags are driven from slice grant in ISSUE and WAIT; 0 in IDLE.

Latency:
- Idle arbiter: req_start at cycle t → hash_start at t+2.
- Back-to-back: next hash_start 2 cycles after hash_done.

Lock:
- Set when an issued job has store_intermediate=1.
- Cleared at hash_done of a job from the same owner with continue_intermediate=1 and store_intermediate=0.
- A job with both flags 1 keeps the lock.

Simultaneous events:
- A req_start in the same cycle as that requester's req_done is accepted as a new job.
- Multiple starts in one cycle are all latched.
- hash_done outside WAIT is ignored.

req_busy[i] = pending[i] | (grant==i & state!=IDLE).

Optional Feature:
HASH_ARB_STATS_EN
- Defined: adds outputs stat_grants (32*NUM_REQ, saturating per-requester completed-job counters) and stat_proto_err (sticky).
  - stat_proto_err is set by an ignored duplicate start or by hash_done outside WAIT.
  - Both clear on reset only.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared header/package: state encodings (ARB_IDLE=2'd0, ARB_ISSUE=2'd1, ARB_WAIT=2'd2), the HASH_BLOCK_W=1024 constant, and the `CLOG2 macro already in use.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: pending mask, last_grant, lock, grant.
  - Outputs: valid and index.
  - Reusable for the memory-port arbiters.

Test Plan:
1. NUM_REQ=2; req_start[1] at cycle 10 with data 1024'hA5… → hash_start at cycle 12 carrying slice 1; hash_done at 30 → req_done=2'b10 at 30; req_done[0] never asserted.
2. req_start=2'b11 same cycle after reset → requester 0 served first, then requester 1; hash_start pulses exactly twice. Repeating the pair → order 0,1 again, since last_grant=1.
3. NUM_REQ=3, all three continuously re-requesting for 9 jobs → grant sequence 0,1,2,0,1,2,0,1,2.
4. Req 0 issues store_intermediate=1 while req 1 is pending → locked=1 and req 1 is not issued. Req 0 then issues continue_intermediate=1, store=0 → after its done, locked=0 and req 1 is issued next.
5. Assert reset during WAIT → all outputs 0 asynchronously, no req_done. After release, a fresh req_start[0] → hash_start 2 cycles later.
6. Duplicate req_start[0] during WAIT → ignored, only one req_done. With HASH_ARB_STATS_EN: stat_proto_err=1, stat_grants[0]=1.

Source files
------------

// File: rtl/hash_arbiter_pkg.sv
// hash_arbiter_pkg: shared definitions for the hash arbiter and its round-robin
// picker: FSM state encoding, the SHA-256 double-block width and `CLOG2.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package hash_arbiter_pkg;

    localparam int HASH_BLOCK_W = 1024;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/hash_arbiter_rr_pick.sv
// hash_arbiter_rr_pick: combinational round-robin selector. Scans the pending
// mask starting just after last_grant and wrapping around. While lock is held
// only the current owner (grant) may be selected. Also usable for the memory
// port arbiters.
module hash_arbiter_rr_pick
    import hash_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int REQ_W   = 1
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [REQ_W-1:0]   last_grant,
    input  logic               lock,
    input  logic [REQ_W-1:0]   grant,
    output logic               valid,
    output logic [REQ_W-1:0]   index
);

    logic [REQ_W-1:0] cand;

    // First pending requester after last_grant, or only the owner while locked
    always_comb begin
        valid = 1'b0;
        index = grant;
        cand  = last_grant;
        if (lock) begin
            valid = pending[grant];
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (int'(last_grant) + k >= NUM_REQ) begin
                    cand = REQ_W'(int'(last_grant) + k - NUM_REQ);
                end else begin
                    cand = REQ_W'(int'(last_grant) + k);
                end
                if (!valid && pending[cand]) begin
                    valid = 1'b1;
                    index = cand;
                end
            end
        end
    end

endmodule

// File: rtl/hash_arbiter.sv
// hash_arbiter: shares one sha256XMSS core among NUM_REQ requesters that each
// keep their own start/done interface. Grants are round-robin and held until
// the core's done; a requester that stores an intermediate state keeps
// exclusive ownership until it continues from that state.
// Build macro HASH_ARB_STATS_EN adds per-requester saturating completed-job
// counters (stat_grants) and a sticky protocol error flag (stat_proto_err).
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module hash_arbiter
    import hash_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int REQ_W   = `CLOG2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_start,
    input  logic [HASH_BLOCK_W*NUM_REQ-1:0] req_data_in,
    input  logic [NUM_REQ-1:0]              req_message_length,
    input  logic [NUM_REQ-1:0]              req_store_intermediate,
    input  logic [NUM_REQ-1:0]              req_continue_intermediate,
    output logic [NUM_REQ-1:0]              req_done,
    output logic [NUM_REQ-1:0]              req_busy,
    output logic                            hash_start,
    output logic [HASH_BLOCK_W-1:0]         hash_data_in,
    output logic                            hash_message_length,
    output logic                            hash_store_intermediate,
    output logic                            hash_continue_intermediate,
    input  logic                            hash_done,
`ifdef HASH_ARB_STATS_EN
    output logic [32*NUM_REQ-1:0]           stat_grants,
    output logic                            stat_proto_err,
`endif
    output logic [REQ_W-1:0]                grant,
    output logic                            locked
);

    arb_state_t               state;
    logic [NUM_REQ-1:0]       pending;
    logic [NUM_REQ-1:0]       grant_onehot;
    logic [NUM_REQ-1:0]       inflight;
    logic [NUM_REQ-1:0]       start_accept;
    logic [REQ_W-1:0]         last_grant;
    logic [REQ_W-1:0]         pick_index;
    logic                     pick_valid;
    logic                     active;
    logic                     job_done;
    logic [HASH_BLOCK_W-1:0]  sel_data;
    logic                     sel_len;
    logic                     sel_store;
    logic                     sel_cont;

    assign active   = (state != ARB_IDLE);
    assign job_done = (state == ARB_WAIT) && hash_done;

    // One-hot form of the current owner index
    always_comb begin
        grant_onehot        = '0;
        grant_onehot[grant] = 1'b1;
    end

    assign req_done = job_done ? grant_onehot : '0;
    assign req_busy = pending | (active ? grant_onehot : '0);

    // A job in flight blocks a restart, except in the cycle its done is returned
    assign inflight     = active ? (grant_onehot & ~req_done) : '0;
    assign start_accept = req_start & ~pending & ~inflight;

    // Route the owner's request fields toward the core
    always_comb begin
        sel_data  = '0;
        sel_len   = 1'b0;
        sel_store = 1'b0;
        sel_cont  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == REQ_W'(i)) begin
                sel_data  = req_data_in[HASH_BLOCK_W*i +: HASH_BLOCK_W];
                sel_len   = req_message_length[i];
                sel_store = req_store_intermediate[i];
                sel_cont  = req_continue_intermediate[i];
            end
        end
    end

    assign hash_data_in               = active ? sel_data  : '0;
    assign hash_message_length        = active ? sel_len   : 1'b0;
    assign hash_store_intermediate    = active ? sel_store : 1'b0;
    assign hash_continue_intermediate = active ? sel_cont  : 1'b0;

    hash_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .REQ_W   (REQ_W)
    ) u_rr_pick (
        .pending    (pending),
        .last_grant (last_grant),
        .lock       (locked),
        .grant      (grant),
        .valid      (pick_valid),
        .index      (pick_index)
    );

    // Latch new start pulses and retire the owner's request once it is issued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~((state == ARB_ISSUE) ? grant_onehot : '0)) | start_accept;
        end
    end

    // Arbitration FSM: pick an owner, pulse the core start, wait for its done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            last_grant <= REQ_W'(NUM_REQ - 1);
            locked     <= 1'b0;
            hash_start <= 1'b0;
        end else begin
            hash_start <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        grant      <= pick_index;
                        hash_start <= 1'b1;
                        state      <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (sel_store) begin
                        locked <= 1'b1;
                    end
                    state <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (hash_done) begin
                        last_grant <= grant;
                        if (sel_cont && !sel_store) begin
                            locked <= 1'b0;
                        end
                        state <= ARB_IDLE;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

`ifdef HASH_ARB_STATS_EN
    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

    logic dup_start;
    logic stray_done;

    assign dup_start  = |(req_start & ~start_accept);
    assign stray_done = hash_done && (state != ARB_WAIT);

    // Count completed jobs per requester and remember any protocol misuse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_grants    <= '0;
            stat_proto_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_done[i] && (stat_grants[32*i +: 32] != STAT_MAX)) begin
                    stat_grants[32*i +: 32] <= stat_grants[32*i +: 32] + 32'd1;
                end
            end
            if (dup_start || stray_done) begin
                stat_proto_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hash_arbiter.sv
// tb_hash_arbiter: self-checking bench for hash_arbiter with three requesters.
// A job-level reference model is compared against the DUT every cycle, and
// directed scenarios pin latency, ordering, locking, reset and duplicate starts.
module tb_hash_arbiter;

    localparam int N  = 3;
    localparam int W  = $clog2(N);
    localparam int BW = 1024;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_start;
    logic [BW*N-1:0]   req_data_in;
    logic [N-1:0]      req_message_length;
    logic [N-1:0]      req_store_intermediate;
    logic [N-1:0]      req_continue_intermediate;
    logic [N-1:0]      req_done;
    logic [N-1:0]      req_busy;
    logic              hash_start;
    logic [BW-1:0]     hash_data_in;
    logic              hash_message_length;
    logic              hash_store_intermediate;
    logic              hash_continue_intermediate;
    wire               hash_done;
    logic [W-1:0]      grant;
    logic              locked;
`ifdef HASH_ARB_STATS_EN
    logic [32*N-1:0]   stat_grants;
    logic              stat_proto_err;
`endif

    logic              core_done;
    logic              stray_done;
    int                total = 0;
    int                bad = 0;
    int                cyc = 0;
    int                core_lat = 4;
    int                hs_count = 0;
    int                hs_cycle = 0;
    int                done_cycle = 0;
    int                done0_count = 0;
    logic [N-1:0]      done_acc;
    logic [N-1:0]      done_last;
    logic [BW-1:0]     hs_data;
    logic [BW-1:0]     data_a5;
    int                grant_log[$];

    assign hash_done = core_done | stray_done;

    hash_arbiter #(
        .NUM_REQ (N)
    ) dut (
        .clk                        (clk),
        .reset                      (reset),
        .req_start                  (req_start),
        .req_data_in                (req_data_in),
        .req_message_length         (req_message_length),
        .req_store_intermediate     (req_store_intermediate),
        .req_continue_intermediate  (req_continue_intermediate),
        .req_done                   (req_done),
        .req_busy                   (req_busy),
        .hash_start                 (hash_start),
        .hash_data_in               (hash_data_in),
        .hash_message_length        (hash_message_length),
        .hash_store_intermediate    (hash_store_intermediate),
        .hash_continue_intermediate (hash_continue_intermediate),
        .hash_done                  (hash_done),
`ifdef HASH_ARB_STATS_EN
        .stat_grants                (stat_grants),
        .stat_proto_err             (stat_proto_err),
`endif
        .grant                      (grant),
        .locked                     (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] starts);
        req_start = starts;
        stepCycle();
        req_start = '0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        stepCycle();
        stepCycle();
        reset = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int max_cycles);
        logic timed_out;
        timed_out = 1'b1;
        for (int k = 0; k < max_cycles; k++) begin
            stepCycle();
            if (req_busy == '0 && hash_done == 1'b0) begin
                timed_out = 1'b0;
                break;
            end
        end
        checkOutput(name, BW'(timed_out), BW'(1'b0));
    endtask

    task automatic waitStart(input string name, input int max_cycles);
        int h;
        logic timed_out;
        h = hs_count;
        timed_out = 1'b1;
        for (int k = 0; k < max_cycles; k++) begin
            stepCycle();
            if (hs_count > h) begin
                timed_out = 1'b0;
                break;
            end
        end
        checkOutput(name, BW'(timed_out), BW'(1'b0));
    endtask

    // Event monitor: records every issue and every completion the DUT reports
    always @(negedge clk) begin
        if (!reset) begin
            if (hash_start) begin
                grant_log.push_back(int'(grant));
                hs_count++;
                hs_cycle = cyc;
                hs_data = hash_data_in;
            end
            if (req_done != '0) begin
                done_acc |= req_done;
                done_last = req_done;
                done_cycle = cyc;
                if (req_done[0]) done0_count++;
            end
        end
    end

    // Core stand-in: raises done core_lat cycles after a start, gives up on reset
    initial begin
        logic aborted;
        core_done = 1'b0;
        forever begin
            @(negedge clk);
            if (hash_start && !reset) begin
                aborted = 1'b0;
                for (int k = 0; k < core_lat; k++) begin
                    @(posedge clk);
                    if (reset) aborted = 1'b1;
                end
                if (!aborted) begin
                    #1 core_done = 1'b1;
                    @(posedge clk);
                    #1 core_done = 1'b0;
                end
            end
        end
    end

    // Job-level reference model, compared with the DUT on every cycle out of reset
    initial begin : model_check
        int m_cur;
        int m_last;
        int m_grant;
        int win;
        int j;
        bit m_issued;
        bit m_lock;
        logic [N-1:0] m_wait;
        logic [N-1:0] acc;
        logic [N-1:0] e_done;
        logic [N-1:0] e_busy;
        logic [BW-1:0] e_data;
        logic e_len;
        logic e_store;
        logic e_cont;
        m_cur = -1; m_last = N - 1; m_grant = 0; m_issued = 0; m_lock = 0; m_wait = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_cur = -1; m_last = N - 1; m_grant = 0; m_issued = 0; m_lock = 0; m_wait = '0;
            end else begin
                e_done = '0; e_busy = m_wait; e_data = '0; e_len = 0; e_store = 0; e_cont = 0;
                if (m_cur >= 0) begin
                    e_busy[m_cur] = 1'b1;
                    e_data  = req_data_in[BW*m_cur +: BW];
                    e_len   = req_message_length[m_cur];
                    e_store = req_store_intermediate[m_cur];
                    e_cont  = req_continue_intermediate[m_cur];
                    if (m_issued && hash_done) e_done[m_cur] = 1'b1;
                end
                checkOutput("m_hash_start", BW'(hash_start), BW'(m_cur >= 0 && !m_issued));
                checkOutput("m_req_done", BW'(req_done), BW'(e_done));
                checkOutput("m_req_busy", BW'(req_busy), BW'(e_busy));
                checkOutput("m_grant", BW'(grant), BW'(m_grant));
                checkOutput("m_locked", BW'(locked), BW'(m_lock));
                checkOutput("m_data", hash_data_in, e_data);
                checkOutput("m_flags", BW'({hash_message_length, hash_store_intermediate, hash_continue_intermediate}),
                            BW'({e_len, e_store, e_cont}));
                acc = '0;
                for (int i = 0; i < N; i++) begin
                    if (req_start[i] && !m_wait[i] && !(i == m_cur && !e_done[i])) acc[i] = 1'b1;
                end
                if (m_cur < 0) begin
                    win = -1;
                    if (m_lock) begin
                        if (m_wait[m_grant]) win = m_grant;
                    end else begin
                        for (int k = 1; k <= N; k++) begin
                            j = (m_last + k) % N;
                            if (win < 0 && m_wait[j]) win = j;
                        end
                    end
                    if (win >= 0) begin
                        m_cur = win; m_grant = win; m_issued = 0;
                    end
                end else if (!m_issued) begin
                    m_issued = 1;
                    m_wait[m_cur] = 1'b0;
                    if (req_store_intermediate[m_cur]) m_lock = 1;
                end else if (hash_done) begin
                    m_last = m_cur;
                    if (req_continue_intermediate[m_cur] && !req_store_intermediate[m_cur]) m_lock = 0;
                    m_cur = -1;
                end
                m_wait |= acc;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        int h0;
        int d0;
        int starts_left;
        logic timed_out;
        logic [N-1:0] s;
        int exp2[4] = '{0, 1, 0, 1};
        int exp3[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
        int exp4[3] = '{0, 0, 1};

        reset = 1'b1;
        req_start = '0;
        stray_done = 1'b0;
        req_message_length = 3'b101;
        req_store_intermediate = '0;
        req_continue_intermediate = '0;
        data_a5 = {128{8'hA5}};
        req_data_in[0*BW +: BW] = {128{8'h3C}};
        req_data_in[1*BW +: BW] = data_a5;
        req_data_in[2*BW +: BW] = {128{8'h96}};
        done_acc = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_grant", BW'(grant), BW'(0));
        checkOutput("rst_locked", BW'(locked), BW'(0));
        checkOutput("rst_busy", BW'(req_busy), BW'(0));
        checkOutput("rst_start", BW'(hash_start), BW'(0));
        checkOutput("rst_done", BW'(req_done), BW'(0));
        checkOutput("rst_data", hash_data_in, '0);

        $display("[TB] single request from requester 1");
        core_lat = 18;
        stepCycle();
        t = cyc;
        applyStimulus(3'b010);
        waitIdle("t1_timeout", 100);
        checkOutput("t1_start_latency", BW'(hs_cycle - t), BW'(2));
        checkOutput("t1_done_latency", BW'(done_cycle - hs_cycle), BW'(18));
        checkOutput("t1_done_vec", BW'(done_last), BW'(3'b010));
        checkOutput("t1_done_acc", BW'(done_acc), BW'(3'b010));
        checkOutput("t1_data", hs_data, data_a5);
        checkOutput("t1_owner", BW'(grant_log.size() > 0 ? grant_log[0] : -1), BW'(1));

        $display("[TB] simultaneous starts, repeated pair");
        core_lat = 4;
        grant_log.delete();
        h0 = hs_count;
        applyStimulus(3'b011);
        waitIdle("t2a_timeout", 100);
        checkOutput("t2_pair1_starts", BW'(hs_count - h0), BW'(2));
        applyStimulus(3'b011);
        waitIdle("t2b_timeout", 100);
        checkOutput("t2_pair2_starts", BW'(hs_count - h0), BW'(4));
        checkOutput("t2_log_size", BW'(grant_log.size()), BW'(4));
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2_order", BW'(i < grant_log.size() ? grant_log[i] : -1), BW'(exp2[i]));
        end
        h0 = hs_count;
        d0 = done_cycle;
        stray_done = 1'b1;
        stepCycle();
        stray_done = 1'b0;
        stepCycle();
        checkOutput("t2_stray_no_start", BW'(hs_count - h0), BW'(0));
        checkOutput("t2_stray_no_done", BW'(done_cycle - d0), BW'(0));

        $display("[TB] three requesters continuously re-requesting");
        doReset();
        grant_log.delete();
        starts_left = 9;
        timed_out = 1'b1;
        for (int k = 0; k < 400; k++) begin
            s = '0;
            for (int i = 0; i < N; i++) begin
                if (!req_busy[i] && starts_left > 0) begin
                    s[i] = 1'b1;
                    starts_left--;
                end
            end
            req_start = s;
            stepCycle();
            if (starts_left == 0 && req_busy == '0 && s == '0) begin
                timed_out = 1'b0;
                break;
            end
        end
        req_start = '0;
        checkOutput("t3_timeout", BW'(timed_out), BW'(0));
        checkOutput("t3_log_size", BW'(grant_log.size()), BW'(9));
        for (int i = 0; i < 9; i++) begin
            checkOutput("t3_order", BW'(i < grant_log.size() ? grant_log[i] : -1), BW'(exp3[i]));
        end

        $display("[TB] intermediate-state lock");
        grant_log.delete();
        req_store_intermediate = 3'b001;
        req_continue_intermediate = 3'b000;
        d0 = done0_count;
        applyStimulus(3'b011);
        waitStart("t4_start_timeout", 50);
        checkOutput("t4_locked_wait", BW'(locked), BW'(1));
        timed_out = 1'b1;
        for (int k = 0; k < 100; k++) begin
            stepCycle();
            if (done0_count > d0) begin
                timed_out = 1'b0;
                break;
            end
        end
        checkOutput("t4_done_timeout", BW'(timed_out), BW'(0));
        checkOutput("t4_locked_after_store", BW'(locked), BW'(1));
        checkOutput("t4_req1_waiting", BW'(req_busy[1]), BW'(1));
        req_store_intermediate = 3'b000;
        req_continue_intermediate = 3'b001;
        applyStimulus(3'b001);
        waitIdle("t4_idle_timeout", 100);
        checkOutput("t4_unlocked", BW'(locked), BW'(0));
        checkOutput("t4_log_size", BW'(grant_log.size()), BW'(3));
        for (int i = 0; i < 3; i++) begin
            checkOutput("t4_order", BW'(i < grant_log.size() ? grant_log[i] : -1), BW'(exp4[i]));
        end
        req_continue_intermediate = 3'b000;

        $display("[TB] reset during WAIT");
        core_lat = 6;
        done_acc = '0;
        applyStimulus(3'b100);
        waitStart("t5_start_timeout", 50);
        #2 reset = 1'b1;
        #1;
        checkOutput("t5_async_done", BW'(req_done), BW'(0));
        checkOutput("t5_async_busy", BW'(req_busy), BW'(0));
        checkOutput("t5_async_start", BW'(hash_start), BW'(0));
        checkOutput("t5_async_grant", BW'(grant), BW'(0));
        checkOutput("t5_async_data", hash_data_in, '0);
        stepCycle();
        stepCycle();
        reset = 1'b0;
        repeat (8) stepCycle();
        checkOutput("t5_no_done", BW'(done_acc), BW'(0));
        t = cyc;
        applyStimulus(3'b001);
        waitIdle("t5_idle_timeout", 100);
        checkOutput("t5_start_latency", BW'(hs_cycle - t), BW'(2));
        checkOutput("t5_owner", BW'(grant_log.size() > 0 ? grant_log[grant_log.size()-1] : -1), BW'(0));

        $display("[TB] duplicate start while in flight");
        core_lat = 4;
        doReset();
        d0 = done0_count;
        h0 = hs_count;
        applyStimulus(3'b001);
        waitStart("t6_start_timeout", 50);
        applyStimulus(3'b001);
        waitIdle("t6_idle_timeout", 100);
        checkOutput("t6_one_done", BW'(done0_count - d0), BW'(1));
        checkOutput("t6_one_start", BW'(hs_count - h0), BW'(1));
`ifdef HASH_ARB_STATS_EN
        checkOutput("t6_proto_err", BW'(stat_proto_err), BW'(1));
        checkOutput("t6_grants0", BW'(stat_grants[31:0]), BW'(1));
        checkOutput("t6_grants12", BW'(stat_grants[95:32]), BW'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
